// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - control-flow sequencer: pc, return stack, data stack pointer, kernel/user mode
// Purpose: executes one decoded instruction per instr_valid strobe.
//          Single-cycle ops are JMP/CALL/RET/SYS/GSA/SWITCH/no-op.
//          PUSH and POP hold the sequencer busy while data memory answers.
// Ports:   clk, reset (sync, active-high), instr_valid, decoder flags, alu_result in;
//          pc, kernel_mode, busy out;
//          data memory: mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in;
//          register file write: reg_we/reg_waddr/reg_wdata;
//          ctx_pulse/ctx_id (context switch), sys_pulse/sys_code (syscall), fault.
// Option:  define SEQ_STACK_GUARD_EN for return-stack overflow/underflow protection
//          with a sticky fault flag; otherwise the stack wraps silently and fault is 0.
module program_sequencer #(
    parameter int          PC_W         = 16,
    parameter int          RSTACK_DEPTH = 8,
    parameter logic [15:0] SP_RESET     = 16'hFFFF,
    parameter logic [15:0] SYS_VECTOR   = 16'h0010
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic            JMP_flag,
    input  logic            CALL_flag,
    input  logic            RET_flag,
    input  logic            PUSH_flag,
    input  logic            POP_flag,
    input  logic            GSA_flag,
    input  logic            SWITCH_flag,
    input  logic            SYS_flag,
    input  logic            Kernel_flag,
    input  logic [31:0]     alu_result,
    output logic [PC_W-1:0] pc,
    output logic            kernel_mode,
    output logic            busy,
    output logic            mem_req,
    output logic            mem_we,
    output logic [15:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ack,
    output logic            reg_we,
    output logic [7:0]      reg_waddr,
    output logic [31:0]     reg_wdata,
    output logic            ctx_pulse,
    output logic [23:0]     ctx_id,
    output logic            sys_pulse,
    output logic [23:0]     sys_code,
    output logic            fault
);

    localparam int RSP_W = $clog2(RSTACK_DEPTH);
    localparam logic [PC_W-1:0] SYS_PC = PC_W'(SYS_VECTOR);

    typedef enum logic [1:0] {IDLE, MEM_WR, MEM_RD, WB} state_t;

    state_t            state, next_state;
    logic [15:0]       sp;
    logic [RSP_W-1:0]  rsp;
    logic [RSP_W-1:0]  rsp_dec;
    logic [PC_W-1:0]   rstack [RSTACK_DEPTH];
    logic [PC_W-1:0]   pc_inc;

    logic accept;
    logic op_sys, op_call, op_ret, op_jmp, op_push, op_pop, op_gsa, op_switch;
    logic stack_full, stack_empty;
    logic push_fault, pop_fault;
    logic stack_push;

    // Flag priority: SYS > CALL > RET > JMP > PUSH > POP > GSA > SWITCH.
    assign op_sys    = SYS_flag;
    assign op_call   = !SYS_flag && CALL_flag;
    assign op_ret    = !SYS_flag && !CALL_flag && RET_flag;
    assign op_jmp    = !SYS_flag && !CALL_flag && !RET_flag && JMP_flag;
    assign op_push   = !SYS_flag && !CALL_flag && !RET_flag && !JMP_flag && PUSH_flag;
    assign op_pop    = !SYS_flag && !CALL_flag && !RET_flag && !JMP_flag && !PUSH_flag && POP_flag;
    assign op_gsa    = !SYS_flag && !CALL_flag && !RET_flag && !JMP_flag && !PUSH_flag && !POP_flag
                       && GSA_flag;
    assign op_switch = !SYS_flag && !CALL_flag && !RET_flag && !JMP_flag && !PUSH_flag && !POP_flag
                       && !GSA_flag && SWITCH_flag;

    assign accept  = instr_valid && (state == IDLE);
    assign pc_inc  = pc + 1'b1;
    assign rsp_dec = rsp - 1'b1;

`ifdef SEQ_STACK_GUARD_EN
    localparam logic [RSP_W:0] OCC_FULL = RSTACK_DEPTH[RSP_W:0];
    logic [RSP_W:0] occ;

    assign stack_full  = (occ == OCC_FULL);
    assign stack_empty = (occ == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            occ   <= '0;
            fault <= 1'b0;
        end else if (accept) begin
            if (push_fault || pop_fault) begin
                fault <= 1'b1;
            end else if (op_sys || op_call) begin
                occ <= occ + 1'b1;
            end else if (op_ret) begin
                occ <= occ - 1'b1;
            end
        end
    end
`else
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b0;
    assign fault       = 1'b0;
`endif

    assign push_fault = (op_sys || op_call) && stack_full;
    assign pop_fault  = op_ret && stack_empty;
    assign stack_push = accept && (op_sys || op_call) && !stack_full && !reset;

    // Memory-facing strobes come straight off the state register.
    assign busy    = (state != IDLE);
    assign mem_req = (state == MEM_WR) || (state == MEM_RD);
    assign mem_we  = (state == MEM_WR);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept && op_push)     next_state = MEM_WR;
                else if (accept && op_pop) next_state = MEM_RD;
            end
            MEM_WR:  if (mem_ack) next_state = IDLE;
            MEM_RD:  if (mem_ack) next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (stack_push) rstack[rsp] <= pc_inc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            kernel_mode <= 1'b1;
            sp          <= SP_RESET;
            rsp         <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            reg_we      <= 1'b0;
            reg_waddr   <= '0;
            reg_wdata   <= '0;
            ctx_pulse   <= 1'b0;
            ctx_id      <= '0;
            sys_pulse   <= 1'b0;
            sys_code    <= '0;
        end else begin
            reg_we    <= 1'b0;
            ctx_pulse <= 1'b0;
            sys_pulse <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    if (op_sys) begin
                        sys_pulse <= 1'b1;
                        sys_code  <= alu_result[23:0];
                        if (push_fault) begin
                            pc <= pc_inc;
                        end else begin
                            rsp         <= rsp + 1'b1;
                            kernel_mode <= 1'b1;
                            pc          <= SYS_PC;
                        end
                    end else if (op_call) begin
                        if (push_fault) begin
                            pc <= pc_inc;
                        end else begin
                            rsp <= rsp + 1'b1;
                            pc  <= alu_result[PC_W-1:0];
                        end
                    end else if (op_ret) begin
                        if (pop_fault) begin
                            pc <= pc_inc;
                        end else begin
                            rsp <= rsp_dec;
                            pc  <= rstack[rsp_dec];
                        end
                    end else if (op_jmp) begin
                        pc <= alu_result[PC_W-1:0];
                        if (Kernel_flag) kernel_mode <= 1'b0;
                    end else if (op_push) begin
                        // sp moves at accept so a reset mid-write leaves no partial state.
                        sp        <= sp - 1'b1;
                        mem_addr  <= sp - 1'b1;
                        mem_wdata <= alu_result;
                    end else if (op_pop) begin
                        mem_addr  <= sp;
                        reg_waddr <= alu_result[7:0];
                    end else if (op_gsa) begin
                        reg_we    <= 1'b1;
                        reg_waddr <= alu_result[7:0];
                        reg_wdata <= {16'b0, sp};
                        pc        <= pc_inc;
                    end else if (op_switch) begin
                        if (kernel_mode) begin
                            ctx_id    <= alu_result[23:0];
                            ctx_pulse <= 1'b1;
                        end
                        pc <= pc_inc;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                MEM_WR: if (mem_ack) pc <= pc_inc;
                MEM_RD: if (mem_ack) begin
                    // reg_we is registered, so it is high during the WB cycle.
                    reg_we    <= 1'b1;
                    reg_wdata <= mem_rdata;
                    sp        <= sp + 1'b1;
                end
                WB:      pc <= pc_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - self-checking bench for program_sequencer
module tb_program_sequencer;

    localparam logic [8:0] F_SYS  = 9'b1_0000_0000;
    localparam logic [8:0] F_CALL = 9'b0_1000_0000;
    localparam logic [8:0] F_RET  = 9'b0_0100_0000;
    localparam logic [8:0] F_JMP  = 9'b0_0010_0000;
    localparam logic [8:0] F_PUSH = 9'b0_0001_0000;
    localparam logic [8:0] F_POP  = 9'b0_0000_1000;
    localparam logic [8:0] F_GSA  = 9'b0_0000_0100;
    localparam logic [8:0] F_SWI  = 9'b0_0000_0010;
    localparam logic [8:0] F_KERN = 9'b0_0000_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [8:0]  fl = '0;
    logic [31:0] alu_result = '0;
    logic [15:0] pc;
    logic        kernel_mode, busy, mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        reg_we;
    logic [7:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        ctx_pulse, sys_pulse, fault;
    logic [23:0] ctx_id, sys_code;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    program_sequencer dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .JMP_flag(fl[5]), .CALL_flag(fl[7]), .RET_flag(fl[6]), .PUSH_flag(fl[4]),
        .POP_flag(fl[3]), .GSA_flag(fl[2]), .SWITCH_flag(fl[1]), .SYS_flag(fl[8]),
        .Kernel_flag(fl[0]), .alu_result(alu_result),
        .pc(pc), .kernel_mode(kernel_mode), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .ctx_pulse(ctx_pulse), .ctx_id(ctx_id), .sys_pulse(sys_pulse), .sys_code(sys_code),
        .fault(fault)
    );

    // Memory responder contents (written by the DUT) and observations of one instruction.
    logic [31:0] tb_mem [logic [15:0]];
    logic        obs_sys, obs_ctx, obs_reg_we, obs_wr, obs_unstable;
    logic [7:0]  obs_waddr;
    logic [31:0] obs_wdata, obs_wr_data;
    logic [15:0] obs_first_addr, obs_wr_addr;
    int          obs_busy;

    // Reference model state.
    logic [15:0] m_pc, m_sp;
    logic        m_kernel, m_fault;
    logic [23:0] m_sys_code, m_ctx_id;
    logic [31:0] m_mem [logic [15:0]];
    logic [15:0] m_q [$];
    logic [15:0] m_ring [8];
    int          m_top;
    logic        e_sys, e_ctx, e_reg_we, e_wr;
    logic [7:0]  e_waddr;
    logic [31:0] e_wdata, e_wr_data;
    logic [15:0] e_wr_addr;

    function automatic logic [31:0] mem_read(input logic [15:0] ad);
        return tb_mem.exists(ad) ? tb_mem[ad] : {16'hA5A5, ad};
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] ad);
        return m_mem.exists(ad) ? m_mem[ad] : {16'hA5A5, ad};
    endfunction

    task automatic model_reset();
        m_pc = '0; m_sp = 16'hFFFF; m_kernel = 1'b1; m_fault = 1'b0;
        m_sys_code = '0; m_ctx_id = '0; m_top = 0;
        m_q.delete(); m_mem.delete();
    endtask

    // Returns 1 when the return-address push is refused (guarded overflow).
    function automatic logic m_push_ret(input logic [15:0] v);
`ifdef SEQ_STACK_GUARD_EN
        if (m_q.size() == 8) return 1'b1;
        m_q.push_back(v);
`else
        m_ring[m_top] = v;
        m_top = (m_top + 1) % 8;
`endif
        return 1'b0;
    endfunction

    function automatic logic m_pop_ret(output logic [15:0] v);
        v = '0;
`ifdef SEQ_STACK_GUARD_EN
        if (m_q.size() == 0) return 1'b1;
        v = m_q.pop_back();
`else
        m_top = (m_top + 7) % 8;
        v = m_ring[m_top];
`endif
        return 1'b0;
    endfunction

    task automatic model_step(input logic [8:0] f, input logic [31:0] a);
        logic [15:0] r;
        e_sys = 0; e_ctx = 0; e_reg_we = 0; e_wr = 0;
        e_waddr = '0; e_wdata = '0; e_wr_addr = '0; e_wr_data = '0;
        if (f[8]) begin
            e_sys = 1; m_sys_code = a[23:0];
            if (m_push_ret(m_pc + 16'd1)) begin m_fault = 1; m_pc = m_pc + 16'd1; end
            else begin m_kernel = 1; m_pc = 16'h0010; end
        end else if (f[7]) begin
            if (m_push_ret(m_pc + 16'd1)) begin m_fault = 1; m_pc = m_pc + 16'd1; end
            else m_pc = a[15:0];
        end else if (f[6]) begin
            if (m_pop_ret(r)) begin m_fault = 1; m_pc = m_pc + 16'd1; end
            else m_pc = r;
        end else if (f[5]) begin
            m_pc = a[15:0];
            if (f[0]) m_kernel = 0;
        end else if (f[4]) begin
            m_sp = m_sp - 16'd1; m_mem[m_sp] = a;
            e_wr = 1; e_wr_addr = m_sp; e_wr_data = a; m_pc = m_pc + 16'd1;
        end else if (f[3]) begin
            e_reg_we = 1; e_waddr = a[7:0]; e_wdata = m_read(m_sp);
            m_sp = m_sp + 16'd1; m_pc = m_pc + 16'd1;
        end else if (f[2]) begin
            e_reg_we = 1; e_waddr = a[7:0]; e_wdata = {16'h0, m_sp}; m_pc = m_pc + 16'd1;
        end else if (f[1]) begin
            if (m_kernel) begin e_ctx = 1; m_ctx_id = a[23:0]; end
            m_pc = m_pc + 16'd1;
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; instr_valid = 1'b0; fl = '0; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one instruction at a negedge and serves memory until busy drops.
    // With inject set, a JMP is held on instr_valid throughout the busy window.
    task automatic issue(input logic [8:0] f, input logic [31:0] a, input int dly, input bit inject);
        int req_n, bound;
        fl = f; alu_result = a; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; fl = '0;
        obs_sys = sys_pulse; obs_ctx = ctx_pulse;
        obs_reg_we = reg_we; obs_waddr = reg_waddr; obs_wdata = reg_wdata;
        obs_wr = 0; obs_unstable = 0; obs_first_addr = mem_addr; obs_wr_addr = '0; obs_wr_data = '0;
        obs_busy = 0; req_n = 0; bound = 0;
        while (busy && bound < 40) begin
            obs_busy++;
            instr_valid = inject; fl = inject ? F_JMP : 9'b0; alu_result = 32'h0000_1234;
            if (mem_req) begin
                if (mem_addr !== obs_first_addr) obs_unstable = 1;
                if (req_n == dly) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        tb_mem[mem_addr] = mem_wdata;
                        obs_wr = 1; obs_wr_addr = mem_addr; obs_wr_data = mem_wdata;
                    end else begin
                        mem_rdata = mem_read(mem_addr);
                    end
                end
                req_n++;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            if (reg_we) begin obs_reg_we = 1; obs_waddr = reg_waddr; obs_wdata = reg_wdata; end
            bound++;
        end
        instr_valid = 1'b0; fl = '0;
        if (busy) begin
            checks++; fails++;
            $display("FAIL busy_timeout: busy still %0b after %0d cycles, required 0", busy, bound);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pc, kernel_mode, busy, mem_req, mem_we, reg_we, ctx_pulse, sys_pulse, fault}
            !== {16'h0, 1'b1, 7'b0}) begin
            fails++;
            $display("FAIL reset_state: pc=%h k=%b busy=%b req=%b we=%b rwe=%b ctx=%b sys=%b fault=%b, required pc=0 k=1 others 0",
                     pc, kernel_mode, busy, mem_req, mem_we, reg_we, ctx_pulse, sys_pulse, fault);
        end
        checks++;
        if ({ctx_id, sys_code} !== 48'h0) begin
            fails++; $display("FAIL reset_ids: ctx_id=%h sys_code=%h, required 0", ctx_id, sys_code);
        end
    endtask

    task automatic test_no_flags();
        do_reset();
        for (int i = 0; i < 3; i++) issue(9'b0, $urandom, 0, 0);
        checks++;
        if (pc !== 16'd3 || kernel_mode !== 1'b1) begin
            fails++; $display("FAIL noflag_pc: pc=%h k=%b, required pc=3 k=1", pc, kernel_mode);
        end
        issue(F_GSA, 32'h0000_0009, 0, 0);
        checks++;
        if (obs_reg_we !== 1'b1 || obs_waddr !== 8'd9 || obs_wdata !== 32'h0000_FFFF || pc !== 16'd4) begin
            fails++;
            $display("FAIL gsa_reset_sp: we=%b addr=%h data=%h pc=%h, required 1 09 0000ffff 0004",
                     obs_reg_we, obs_waddr, obs_wdata, pc);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        issue(F_JMP, 32'h0000_0005, 0, 0);
        issue(F_CALL, 32'h0000_0040, 0, 0);
        checks++;
        if (pc !== 16'h0040) begin fails++; $display("FAIL call_target: pc=%h, required 0040", pc); end
        issue(F_RET, 32'hFFFF_FFFF, 0, 0);
        checks++;
        if (pc !== 16'h0006) begin fails++; $display("FAIL ret_target: pc=%h, required 0006", pc); end
        issue(F_JMP, 32'h0000_0006, 0, 0);
        checks++;
        if (pc !== 16'h0006) begin fails++; $display("FAIL jmp_halt: pc=%h, required 0006", pc); end
    endtask

    task automatic test_push_pop();
        do_reset();
        tb_mem.delete();
        issue(F_PUSH, 32'hDEAD_BEEF, 2, 1);
        checks++;
        if (obs_first_addr !== 16'hFFFE || obs_wr !== 1'b1 || obs_wr_addr !== 16'hFFFE
            || obs_wr_data !== 32'hDEAD_BEEF || obs_unstable !== 1'b0) begin
            fails++;
            $display("FAIL push_mem: addr=%h wr=%b waddr=%h wdata=%h unstable=%b, required fffe 1 fffe deadbeef 0",
                     obs_first_addr, obs_wr, obs_wr_addr, obs_wr_data, obs_unstable);
        end
        checks++;
        if (obs_busy !== 3 || pc !== 16'd1) begin
            fails++; $display("FAIL push_timing: busy_cycles=%0d pc=%h, required 3 0001", obs_busy, pc);
        end
        issue(F_POP, 32'h0000_0003, 0, 0);
        checks++;
        if (obs_reg_we !== 1'b1 || obs_waddr !== 8'd3 || obs_wdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL pop_wb: we=%b addr=%h data=%h, required 1 03 deadbeef", obs_reg_we, obs_waddr, obs_wdata);
        end
        checks++;
        if (obs_busy !== 2 || pc !== 16'd2) begin
            fails++; $display("FAIL pop_timing: busy_cycles=%0d pc=%h, required 2 0002", obs_busy, pc);
        end
        issue(F_GSA, 32'h0000_0001, 0, 0);
        checks++;
        if (obs_wdata !== 32'h0000_FFFF) begin
            fails++; $display("FAIL pop_sp: sp=%h, required 0000ffff", obs_wdata);
        end
    endtask

    task automatic test_sys();
        do_reset();
        issue(F_JMP | F_KERN, 32'h0000_0020, 0, 0);
        checks++;
        if (pc !== 16'h0020 || kernel_mode !== 1'b0) begin
            fails++; $display("FAIL user_entry: pc=%h k=%b, required 0020 0", pc, kernel_mode);
        end
        issue(F_SYS, 32'h0000_0007, 0, 0);
        checks++;
        if (pc !== 16'h0010 || kernel_mode !== 1'b1 || obs_sys !== 1'b1 || sys_code !== 24'd7) begin
            fails++;
            $display("FAIL sys_entry: pc=%h k=%b pulse=%b code=%h, required 0010 1 1 000007",
                     pc, kernel_mode, obs_sys, sys_code);
        end
        @(negedge clk);
        checks++;
        if (sys_pulse !== 1'b0) begin fails++; $display("FAIL sys_pulse_width: pulse=%b, required 0", sys_pulse); end
        issue(F_RET, 32'h0, 0, 0);
        checks++;
        if (pc !== 16'h0021) begin fails++; $display("FAIL sys_ret: pc=%h, required 0021", pc); end
    endtask

    task automatic test_stack_depth();
        do_reset();
        for (int i = 0; i < 9; i++) issue(F_CALL, 32'h100 + 32'(i * 16), 0, 0);
`ifdef SEQ_STACK_GUARD_EN
        checks++;
        if (fault !== 1'b1 || pc !== 16'h0171) begin
            fails++; $display("FAIL guard_overflow: fault=%b pc=%h, required 1 0171", fault, pc);
        end
        issue(F_RET, 32'h0, 0, 0);
        checks++;
        if (pc !== 16'h0161 || fault !== 1'b1) begin
            fails++; $display("FAIL guard_ret: pc=%h fault=%b, required 0161 1", pc, fault);
        end
`else
        checks++;
        if (fault !== 1'b0 || pc !== 16'h0180) begin
            fails++; $display("FAIL wrap_call: fault=%b pc=%h, required 0 0180", fault, pc);
        end
        issue(F_RET, 32'h0, 0, 0);
        checks++;
        if (pc !== 16'h0171) begin fails++; $display("FAIL wrap_ret0: pc=%h, required 0171", pc); end
        issue(F_RET, 32'h0, 0, 0);
        checks++;
        if (pc !== 16'h0161) begin fails++; $display("FAIL wrap_ret1: pc=%h, required 0161", pc); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        fl = F_POP; alu_result = 32'h5; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; fl = '0;
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== 16'hFFFF) begin
            fails++; $display("FAIL midrst_pre: req=%b busy=%b addr=%h, required 1 1 ffff", mem_req, busy, mem_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || pc !== 16'h0 || reg_we !== 1'b0) begin
            fails++;
            $display("FAIL midrst_post: req=%b busy=%b pc=%h rwe=%b, required 0 0 0000 0", mem_req, busy, pc, reg_we);
        end
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL midrst_late: rwe=%b busy=%b, required 0 0", reg_we, busy);
        end
        issue(F_GSA, 32'h2, 0, 0);
        checks++;
        if (obs_wdata !== 32'h0000_FFFF) begin
            fails++; $display("FAIL midrst_sp: sp=%h, required 0000ffff", obs_wdata);
        end
    endtask

    task automatic test_random();
        logic [8:0]  f;
        logic [31:0] a;
        int          op;
        do_reset();
        tb_mem.delete();
        for (int i = 0; i < 260; i++) begin
            a = $urandom;
            if (i < 8) begin
                f = F_CALL;
            end else begin
                op = $urandom_range(0, 8);
                f = (op == 8) ? 9'b0 : (9'b10 << op);
                if ($urandom_range(0, 3) == 0) f = f | 9'($urandom_range(0, 511));
                f[0] = ($urandom_range(0, 3) == 0);
            end
            model_step(f, a);
            issue(f, a, $urandom_range(0, 3), 0);
            checks++;
            if (pc !== m_pc || kernel_mode !== m_kernel || fault !== m_fault) begin
                fails++;
                $display("FAIL rnd_state[%0d] f=%b: pc=%h k=%b fault=%b, required %h %b %b",
                         i, f, pc, kernel_mode, fault, m_pc, m_kernel, m_fault);
            end
            checks++;
            if (obs_sys !== e_sys || sys_code !== m_sys_code || obs_ctx !== e_ctx || ctx_id !== m_ctx_id) begin
                fails++;
                $display("FAIL rnd_pulse[%0d] f=%b: sys=%b code=%h ctx=%b id=%h, required %b %h %b %h",
                         i, f, obs_sys, sys_code, obs_ctx, ctx_id, e_sys, m_sys_code, e_ctx, m_ctx_id);
            end
            checks++;
            if (obs_reg_we !== e_reg_we || (e_reg_we && (obs_waddr !== e_waddr || obs_wdata !== e_wdata))) begin
                fails++;
                $display("FAIL rnd_reg[%0d] f=%b: we=%b addr=%h data=%h, required %b %h %h",
                         i, f, obs_reg_we, obs_waddr, obs_wdata, e_reg_we, e_waddr, e_wdata);
            end
            checks++;
            if (obs_wr !== e_wr || (e_wr && (obs_wr_addr !== e_wr_addr || obs_wr_data !== e_wr_data))) begin
                fails++;
                $display("FAIL rnd_mem[%0d] f=%b: wr=%b addr=%h data=%h, required %b %h %h",
                         i, f, obs_wr, obs_wr_addr, obs_wr_data, e_wr, e_wr_addr, e_wr_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_flags();
        test_call_ret();
        test_push_pop();
        test_sys();
        test_stack_depth();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
